result_serializer_24to1: RTL and testbench



---
 rtl/result_serializer_24to1_pkg.sv | 24 ++
 rtl/result_serializer_24to1_snapshot_bank_24x32.sv | 34 +++
 rtl/result_serializer_24to1.sv | 129 ++++++++++++
 tb/tb_result_serializer_24to1.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/result_serializer_24to1_pkg.sv
// Shared constants and state encoding for the 24-word result return path.
// The address numbering matches the 24-way parameter loader.
package result_serializer_24to1_pkg;

  localparam int N_WORDS   = 24;
  localparam int WIDTH     = 32;
  localparam int ADDR_W    = 7;
  localparam int BASE_ADDR = 1;
  localparam int IDX_W     = 5;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Address tag carried by the word at bank position idx.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] idx);
    return ADDR_W'(BASE_ADDR) + ADDR_W'(idx);
  endfunction

endpackage

// File: rtl/result_serializer_24to1_snapshot_bank_24x32.sv
// 24 x 32-bit snapshot register bank: captures every word on load,
// and returns one word selected by rd_idx.
module snapshot_bank_24x32
  import result_serializer_24to1_pkg::*;
(
  input  logic                       clk,
  input  logic                       load,
  input  logic [N_WORDS*WIDTH-1:0]   wr_data,
  input  logic [IDX_W-1:0]           rd_idx,
  output logic [WIDTH-1:0]           rd_data
);

  logic [WIDTH-1:0] mem_r [N_WORDS];

  // Capture all words together on the load strobe.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < N_WORDS; k++) begin
        mem_r[k] <= wr_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Index-selected read; positions beyond the bank read as zero.
  always_comb begin
    rd_data = '0;
    if (rd_idx < IDX_W'(N_WORDS)) begin
      rd_data = mem_r[rd_idx];
    end else begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/result_serializer_24to1.sv
// Snapshots 24 signed result lines on start and streams them out one
// address-tagged word per accepted valid/ready beat.
module result_serializer_24to1
  import result_serializer_24to1_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [WIDTH-1:0]  line0,
  input  logic signed [WIDTH-1:0]  line1,
  input  logic signed [WIDTH-1:0]  line2,
  input  logic signed [WIDTH-1:0]  line3,
  input  logic signed [WIDTH-1:0]  line4,
  input  logic signed [WIDTH-1:0]  line5,
  input  logic signed [WIDTH-1:0]  line6,
  input  logic signed [WIDTH-1:0]  line7,
  input  logic signed [WIDTH-1:0]  line8,
  input  logic signed [WIDTH-1:0]  line9,
  input  logic signed [WIDTH-1:0]  line10,
  input  logic signed [WIDTH-1:0]  line11,
  input  logic signed [WIDTH-1:0]  line12,
  input  logic signed [WIDTH-1:0]  line13,
  input  logic signed [WIDTH-1:0]  line14,
  input  logic signed [WIDTH-1:0]  line15,
  input  logic signed [WIDTH-1:0]  line16,
  input  logic signed [WIDTH-1:0]  line17,
  input  logic signed [WIDTH-1:0]  line18,
  input  logic signed [WIDTH-1:0]  line19,
  input  logic signed [WIDTH-1:0]  line20,
  input  logic signed [WIDTH-1:0]  line21,
  input  logic signed [WIDTH-1:0]  line22,
  input  logic signed [WIDTH-1:0]  line23,
  output logic signed [WIDTH-1:0]  dout,
  output logic [ADDR_W-1:0]        addr_out,
  output logic                     valid,
  input  logic                     ready,
  output logic                     busy,
  output logic                     done
);

  state_e                   state_r;
  logic [IDX_W-1:0]         index_r;
  logic [IDX_W-1:0]         rd_idx_s;
  logic [WIDTH-1:0]         bank_word_s;
  logic [N_WORDS*WIDTH-1:0] lines_flat_s;
  logic                     load_s;

  assign lines_flat_s = {line23, line22, line21, line20, line19, line18,
                         line17, line16, line15, line14, line13, line12,
                         line11, line10, line9,  line8,  line7,  line6,
                         line5,  line4,  line3,  line2,  line1,  line0};

  assign load_s = (state_r == ST_IDLE) && start;

  // Word presented after the current one is accepted.
  always_comb begin
    rd_idx_s = '0;
    if (index_r == LAST_IDX) begin
      rd_idx_s = '0;
    end else begin
      rd_idx_s = index_r + 5'd1;
    end
  end

  snapshot_bank_24x32 u_bank (
    .clk     (clk),
    .load    (load_s),
    .wr_data (lines_flat_s),
    .rd_idx  (rd_idx_s),
    .rd_data (bank_word_s)
  );

  // Transfer FSM, index counter and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      index_r  <= 5'd0;
      dout     <= 32'sd0;
      addr_out <= 7'd0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            // The bank is only written at this edge, so word 0 comes straight from line0.
            state_r  <= ST_SEND;
            index_r  <= 5'd0;
            dout     <= line0;
            addr_out <= addr_of(5'd0);
            valid    <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_SEND: begin
          if (valid && ready) begin
            if (index_r == LAST_IDX) begin
              state_r <= ST_DONE;
              index_r <= 5'd0;
              valid   <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              index_r  <= rd_idx_s;
              dout     <= bank_word_s;
              addr_out <= addr_of(rd_idx_s);
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done    <= 1'b0;
          valid   <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          index_r <= 5'd0;
          valid   <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_serializer_24to1.sv
// Directed scoreboard bench for result_serializer_24to1: expected words are
// queued when start is driven and popped on every accepted beat.
module tb_result_serializer_24to1;

  logic clk = 1'b0;
  logic rst, start, ready;
  logic signed [31:0] lines [24];
  logic signed [31:0] dout;
  logic [6:0] addr_out;
  logic valid, busy, done;

  typedef struct packed {
    logic [6:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int beat_cnt = 0;
  int c0 = 0;
  int d0 = 0;
  bit seen_done = 1'b0;
  bit hold_pending = 1'b0;
  logic [31:0] held_d;
  logic [6:0] held_a;
  logic [6:0] last_addr;

  always #5 clk = ~clk;

  result_serializer_24to1 dut (
    .clk(clk), .rst(rst), .start(start),
    .line0(lines[0]),   .line1(lines[1]),   .line2(lines[2]),   .line3(lines[3]),
    .line4(lines[4]),   .line5(lines[5]),   .line6(lines[6]),   .line7(lines[7]),
    .line8(lines[8]),   .line9(lines[9]),   .line10(lines[10]), .line11(lines[11]),
    .line12(lines[12]), .line13(lines[13]), .line14(lines[14]), .line15(lines[15]),
    .line16(lines[16]), .line17(lines[17]), .line18(lines[18]), .line19(lines[19]),
    .line20(lines[20]), .line21(lines[21]), .line22(lines[22]), .line23(lines[23]),
    .dout(dout), .addr_out(addr_out), .valid(valid), .ready(ready),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_all();
    for (int k = 0; k < 24; k++) sb.push_back('{a: 7'(k + 1), d: lines[k]});
  endtask

  // Inspect the current cycle's outputs, then advance past one rising edge.
  task automatic step();
    exp_t e;
    if (done === 1'b1) begin
      done_cnt++;
      seen_done = 1'b1;
      done_cyc = cyc;
      chk("busy_at_done", 32'(busy), 32'd0);
      chk("valid_at_done", 32'(valid), 32'd0);
    end
    if (valid === 1'b1) begin
      if (hold_pending) begin
        chk("hold_data", dout, held_d);
        chk("hold_addr", 32'(addr_out), 32'(held_a));
      end
      if (ready === 1'b1) begin
        chk("busy_in_send", 32'(busy), 32'd1);
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("beat_data", dout, e.d);
          chk("beat_addr", 32'(addr_out), 32'(e.a));
        end
        last_addr = addr_out;
        beat_cnt++;
        hold_pending = 1'b0;
      end else begin
        hold_pending = 1'b1;
        held_d = dout;
        held_a = addr_out;
      end
    end else begin
      hold_pending = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_until_done(input int budget);
    seen_done = 1'b0;
    for (int n = 0; n < budget && !seen_done; n++) step();
    chk("done_seen", 32'(seen_done), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ready = 1'b1;
    for (int k = 0; k < 24; k++) lines[k] = 32'sd0;
    step(); step();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_addr", 32'(addr_out), 32'd0);
    rst = 1'b0;
    step();

    // Full-rate stream
    for (int k = 0; k < 24; k++) lines[k] = k * 1000 - 5000;
    beat_cnt = 0; push_all(); c0 = cyc;
    start = 1'b1; step(); start = 1'b0;
    chk("first_valid", 32'(valid), 32'd1);
    chk("first_addr", 32'(addr_out), 32'd1);
    run_until_done(40);
    chk("full_beats", 32'(beat_cnt), 32'd24);
    chk("full_done_lat", 32'(done_cyc - c0), 32'd25);
    chk("full_sb_empty", 32'(sb.size()), 32'd0);
    chk("done_one_cycle", 32'(done), 32'd0);
    step();

    // Backpressure 1,0,0,1 repeating
    for (int k = 0; k < 24; k++) lines[k] = (k * 37) ^ 32'h5A5A_0000;
    beat_cnt = 0; push_all();
    start = 1'b1; step(); start = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 200 && !seen_done; i++) begin
      ready = (i % 4 == 0) || (i % 4 == 3);
      step();
    end
    chk("bp_done_seen", 32'(seen_done), 32'd1);
    chk("bp_beats", 32'(beat_cnt), 32'd24);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);
    ready = 1'b1;
    step();

    // Snapshot isolation
    for (int k = 0; k < 24; k++) lines[k] = -(k + 1) * 12345;
    beat_cnt = 0; push_all();
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 24; k++) lines[k] = 32'sh7FFF_FFFF;
    run_until_done(40);
    chk("iso_beats", 32'(beat_cnt), 32'd24);
    chk("iso_sb_empty", 32'(sb.size()), 32'd0);

    // Start held high through SEND and DONE
    for (int k = 0; k < 24; k++) lines[k] = k * 3 - 40;
    beat_cnt = 0; d0 = done_cnt; push_all();
    start = 1'b1; step();
    run_until_done(40);
    chk("hold_start_idle", 32'(valid), 32'd0);
    chk("hold_start_1done", 32'(done_cnt - d0), 32'd1);
    chk("hold_start_beats", 32'(beat_cnt), 32'd24);
    push_all(); step(); start = 1'b0;
    chk("restart_addr", 32'(addr_out), 32'd1);
    run_until_done(40);
    chk("restart_2done", 32'(done_cnt - d0), 32'd2);
    chk("restart_sb_empty", 32'(sb.size()), 32'd0);
    step();

    // Reset mid-stream after addr 10 is accepted
    for (int k = 0; k < 24; k++) lines[k] = 1000000 - k * 77;
    last_addr = 7'd0; d0 = done_cnt; push_all();
    start = 1'b1; step(); start = 1'b0;
    for (int n = 0; n < 40 && last_addr != 7'd10; n++) step();
    chk("mid_reached10", 32'(last_addr), 32'd10);
    ready = 1'b0; rst = 1'b1; step(); rst = 1'b0; ready = 1'b1;
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_dout", dout, 32'd0);
    chk("mid_rst_addr", 32'(addr_out), 32'd0);
    sb.delete();
    for (int n = 0; n < 4; n++) step();
    chk("mid_no_done", 32'(done_cnt - d0), 32'd0);

    // Ready low for 5 cycles after start
    for (int k = 0; k < 24; k++) lines[k] = k * 11 + 3;
    beat_cnt = 0; push_all();
    ready = 1'b0; start = 1'b1; step(); start = 1'b0;
    for (int n = 0; n < 5; n++) begin
      chk("stall_valid", 32'(valid), 32'd1);
      chk("stall_addr", 32'(addr_out), 32'd1);
      chk("stall_data", dout, 32'd3);
      step();
    end
    ready = 1'b1; step();
    chk("stall_next_addr", 32'(addr_out), 32'd2);
    run_until_done(40);
    chk("stall_beats", 32'(beat_cnt), 32'd24);
    chk("stall_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
